// File: rtl/rv32imc_types.sv
// Shared rv32imc type definitions: load/store width encodings and the
// data-memory responder FSM state.
package rv32imc_types;

  typedef enum logic [2:0] {
    MEM_LB  = 3'b000,
    MEM_LH  = 3'b001,
    MEM_LW  = 3'b010,
    MEM_LBU = 3'b100,
    MEM_LHU = 3'b101
  } mem_funct3_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dmem_resp_state_t;

  // Wide enough for any latency in 1..15.
  localparam int DMEM_CNT_W = 4;

  function automatic logic dmem_is_req(input logic [3:0] rmask, input logic [3:0] wmask);
    return (|rmask) || (|wmask);
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port word array with per-byte write enables and a registered read
// port. Contents are not reset.
module dmem_sram_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic [3:0]            i_wmask,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_rdata;

  // An enabled access with an all-zero byte mask is a read; the read register
  // only moves on reads so it holds the last returned word.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wmask[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
      if (i_wmask == 4'b0000) begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one byte-masked request at a time, waits a
// fixed latency, then performs the access and pulses dmem_resp.
module dmem_responder
  import rv32imc_types::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        busy,
  output logic        protocol_err
);

  localparam logic [DMEM_CNT_W-1:0] LAT_M1 = DMEM_CNT_W'(LATENCY - 1);

  dmem_resp_state_t        r_state, w_state_next;
  logic [DMEM_CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [3:0]              r_wmask;
  logic [31:0]             r_wdata;
  logic                    r_resp;
  logic                    r_rdata_valid;
  logic                    r_perr;

  logic                    w_req;
  logic                    w_accept;
  logic                    w_complete;
  logic                    w_acc_en;
  logic [DEPTH_LOG2-1:0]   w_req_idx;
  logic [DEPTH_LOG2-1:0]   w_acc_idx;
  logic [3:0]              w_acc_wmask;
  logic [31:0]             w_acc_wdata;
  logic [31:0]             w_sram_rdata;
  logic                    w_unused_addr;

  assign w_req         = dmem_is_req(dmem_rmask, dmem_wmask);
  assign w_accept      = (r_state == IDLE) && w_req;
  assign w_req_idx     = dmem_addr[DEPTH_LOG2+1:2];
  assign w_unused_addr = ^{dmem_addr[31:DEPTH_LOG2+2], dmem_addr[1:0]};

  // With LATENCY=1 the access happens at the acceptance edge straight from the
  // request port; otherwise it is replayed from the captured registers.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_complete   = 1'b0;
    w_acc_idx    = r_idx;
    w_acc_wmask  = r_wmask;
    w_acc_wdata  = r_wdata;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          if (LAT_M1 == '0) begin
            w_complete  = 1'b1;
            w_acc_idx   = w_req_idx;
            w_acc_wmask = dmem_wmask;
            w_acc_wdata = dmem_wdata;
          end else begin
            w_state_next = BUSY;
            w_cnt_next   = LAT_M1;
          end
        end
      end
      BUSY: begin
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt <= DMEM_CNT_W'(1)) begin
          w_complete   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Gated by rst_n so nothing reaches the array while reset is held.
  assign w_acc_en = w_complete && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_wmask       <= '0;
      r_wdata       <= '0;
      r_resp        <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_perr        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_resp  <= w_complete;
      if (w_accept) begin
        r_idx   <= w_req_idx;
        r_wmask <= dmem_wmask;
        r_wdata <= dmem_wdata;
      end
      if (w_complete) begin
        r_rdata_valid <= (w_acc_wmask == 4'b0000);
      end
      if ((w_req && r_state == BUSY) || ((|dmem_rmask) && (|dmem_wmask))) begin
        r_perr <= 1'b1;
      end
    end
  end

  dmem_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_acc_en),
    .i_wmask (w_acc_wmask),
    .i_idx   (w_acc_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_sram_rdata)
  );

  assign dmem_rdata   = r_rdata_valid ? w_sram_rdata : 32'h0;
  assign dmem_resp    = r_resp;
  assign busy         = (r_state == BUSY);
  assign protocol_err = r_perr;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 4) sharing a clock,
// a response scoreboard, a table of single accesses and hand-written corner cases.
module tb_dmem_responder;

  typedef struct packed {
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    int          k;
    logic [31:0] rdata;
    int          cyc;
    int          tag;
  } sb_t;

  logic        clk;
  logic        rstn [3];
  logic [31:0] ad   [3];
  logic [3:0]  rm   [3];
  logic [3:0]  wm   [3];
  logic [31:0] wd   [3];
  logic [31:0] rd   [3];
  logic        rsp  [3];
  logic        bsy  [3];
  logic        perr [3];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tag = 0;
  sb_t  sb [$];
  sb_t  m;
  vec_t tbl [9];

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rstn[0]), .dmem_addr(ad[0]), .dmem_rmask(rm[0]), .dmem_wmask(wm[0]),
    .dmem_wdata(wd[0]), .dmem_rdata(rd[0]), .dmem_resp(rsp[0]), .busy(bsy[0]), .protocol_err(perr[0]));
  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rstn[1]), .dmem_addr(ad[1]), .dmem_rmask(rm[1]), .dmem_wmask(wm[1]),
    .dmem_wdata(wd[1]), .dmem_rdata(rd[1]), .dmem_resp(rsp[1]), .busy(bsy[1]), .protocol_err(perr[1]));
  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rstn[2]), .dmem_addr(ad[2]), .dmem_rmask(rm[2]), .dmem_wmask(wm[2]),
    .dmem_wdata(wd[2]), .dmem_rdata(rd[2]), .dmem_resp(rsp[2]), .busy(bsy[2]), .protocol_err(perr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive one request cycle on instance k; if a response is due, record it.
  task automatic put(input int k, input logic [3:0] r, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] e, input bit exp_rsp);
    @(posedge clk); #1;
    rm[k] = r; wm[k] = w; ad[k] = a; wd[k] = d;
    if (exp_rsp) begin
      sb_t s;
      s.k = k; s.rdata = e; s.cyc = cyc + lat(k); s.tag = tag;
      sb.push_back(s);
    end
    $display("req inst%0d tag%0d rmask=%h wmask=%h addr=%h wdata=%h resp_expected=%0d",
             k, tag, r, w, a, d, exp_rsp);
    tag++;
  endtask

  task automatic idle(input int k);
    @(posedge clk); #1;
    rm[k] = 4'h0; wm[k] = 4'h0;
  endtask

  // Wait (bounded) for all expected responses, then a few quiet cycles so
  // any stray response is seen by the monitor.
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rsp[k] === 1'b1) begin
        if (sb.size() == 0 || sb[0].k != k) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_resp: got response on inst%0d at cycle %0d, expected none", k, cyc);
        end else begin
          m = sb.pop_front();
          $display("rsp inst%0d tag%0d cycle=%0d rdata=%h", k, m.tag, cyc, rd[k]);
          chk("resp_cycle", cyc, m.cyc);
          chk("resp_rdata", rd[k], m.rdata);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0; ad[k] = '0; rm[k] = '0; wm[k] = '0; wd[k] = '0;
    end
    tbl[0] = '{4'h0, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{4'hF, 4'h0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
    tbl[2] = '{4'h0, 4'h4, 32'h0000_0100, 32'h005A_0000, 32'h0};
    tbl[3] = '{4'hF, 4'h0, 32'h0000_0100, 32'h0,         32'hDE5A_BEEF};
    tbl[4] = '{4'h0, 4'hF, 32'h1000_0010, 32'hCAFE_F00D, 32'h0};
    tbl[5] = '{4'hF, 4'h0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D};
    tbl[6] = '{4'h0, 4'hF, 32'h0000_0104, 32'h1122_3344, 32'h0};
    tbl[7] = '{4'h0, 4'h9, 32'h0000_0107, 32'hAA00_00BB, 32'h0};
    tbl[8] = '{4'h1, 4'h0, 32'h0000_0104, 32'h0,         32'hAA22_33BB};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_rdata", rd[k], 32'h0);
      chk("reset_resp", {31'h0, rsp[k]}, 32'h0);
      chk("reset_busy", {31'h0, bsy[k]}, 32'h0);
      chk("reset_perr", {31'h0, perr[k]}, 32'h0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rstn[k] = 1'b1;

    // Single accesses on LATENCY=2: write/read, byte merge, aliasing, partial masks.
    for (int i = 0; i < 9; i++) begin
      put(0, tbl[i].rmask, tbl[i].wmask, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 1'b1);
      idle(0);
      drain();
    end
    chk("no_perr_l2", {31'h0, perr[0]}, 32'h0);

    // Request while busy is dropped and flags an error.
    put(0, 4'hF, 4'h0, 32'h100, 32'h0, 32'hDE5A_BEEF, 1'b1);
    put(0, 4'h0, 4'hF, 32'h100, 32'hFFFF_FFFF, 32'h0, 1'b0);
    @(negedge clk);
    chk("busy_l2", {31'h0, bsy[0]}, 32'h1);
    idle(0);
    drain();
    chk("perr_busy_drop", {31'h0, perr[0]}, 32'h1);
    put(0, 4'hF, 4'h0, 32'h100, 32'h0, 32'hDE5A_BEEF, 1'b1);
    idle(0);
    drain();

    // Back-to-back on LATENCY=1: consecutive writes then consecutive reads.
    put(1, 4'h0, 4'hF, 32'h0, 32'h1111_1111, 32'h0, 1'b1);
    put(1, 4'h0, 4'hF, 32'h4, 32'h2222_2222, 32'h0, 1'b1);
    put(1, 4'h0, 4'hF, 32'h8, 32'h3333_3333, 32'h0, 1'b1);
    put(1, 4'hF, 4'h0, 32'h0, 32'h0, 32'h1111_1111, 1'b1);
    put(1, 4'hF, 4'h0, 32'h4, 32'h0, 32'h2222_2222, 1'b1);
    put(1, 4'hF, 4'h0, 32'h8, 32'h0, 32'h3333_3333, 1'b1);
    idle(1);
    drain();
    chk("no_perr_l1", {31'h0, perr[1]}, 32'h0);
    chk("busy_l1_never", {31'h0, bsy[1]}, 32'h0);

    // Both masks set: performs the write and flags an error.
    put(1, 4'hF, 4'h1, 32'h0, 32'h0000_00EE, 32'h0, 1'b1);
    idle(1);
    drain();
    chk("perr_both_masks", {31'h0, perr[1]}, 32'h1);
    put(1, 4'hF, 4'h0, 32'h0, 32'h0, 32'h1111_11EE, 1'b1);
    idle(1);
    drain();

    // Reset mid-flight on LATENCY=4: pending write discarded, outputs cleared.
    put(2, 4'h0, 4'hF, 32'h20, 32'hA5A5_A5A5, 32'h0, 1'b1);
    idle(2);
    drain();
    put(2, 4'hF, 4'h0, 32'h20, 32'h0, 32'hA5A5_A5A5, 1'b1);
    idle(2);
    drain();
    put(2, 4'h0, 4'hF, 32'h20, 32'h1234_5678, 32'h0, 1'b0);
    idle(2);
    @(negedge clk);
    chk("busy_l4", {31'h0, bsy[2]}, 32'h1);
    @(posedge clk); #1;
    rstn[2] = 1'b0;
    @(negedge clk);
    chk("midrst_rdata", rd[2], 32'h0);
    chk("midrst_busy", {31'h0, bsy[2]}, 32'h0);
    chk("midrst_resp", {31'h0, rsp[2]}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rstn[2] = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_resp_after", {31'h0, rsp[2]}, 32'h0);
    put(2, 4'hF, 4'h0, 32'h20, 32'h0, 32'hA5A5_A5A5, 1'b1);
    idle(2);
    drain();
    put(2, 4'h0, 4'hF, 32'h20, 32'h0, 32'h0, 1'b1);
    idle(2);
    drain();
    put(2, 4'hF, 4'h0, 32'h20, 32'h0, 32'h0, 1'b1);
    idle(2);
    drain();
    chk("no_perr_l4", {31'h0, perr[2]}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the rv32imc core: the far end of the `dmem_*` request port driven by the memory pipeline stage. It accepts one-cycle byte-masked read/write requests, models a fixed access latency with a counter and FSM, and returns a registered full-word response. The hazard unit consumes `busy`/`dmem_resp` to generate `mem_stall`. It is used as the simulation/FPGA data memory and as the reference responder for future cache/bus bridges.

## Interface
- `DEPTH_LOG2`, 10: word-array depth is 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, 2: edges from request acceptance to `dmem_resp`; legal range 1..15.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `dmem_addr  in  32`: word-aligned byte address; bits [1:0] ignored.
- `dmem_rmask  in  4`: byte read mask; nonzero = read request this cycle.
- `dmem_wmask  in  4`: byte write mask; nonzero = write request this cycle.
- `dmem_wdata  in  32`: write data, byte lanes already positioned.
- `dmem_rdata  out  32`: read data, full word, valid when `dmem_resp`.
- `dmem_resp  out  1`: one-cycle completion pulse for reads and writes.
- `busy  out  1`: request in flight (state BUSY).
- `protocol_err  out  1`: sticky error flag.

## Operation
- States: IDLE, BUSY. Reset → IDLE; outputs `dmem_rdata`=0, `dmem_resp`=0, `busy`=0, `protocol_err`=0; counter=0.
- Request = `|dmem_rmask | |dmem_wmask`, sampled at the rising edge.
- IDLE + request: capture word index `dmem_addr[DEPTH_LOG2+1:2]`, both masks, and `dmem_wdata`; load counter with LATENCY-1; go to BUSY.
- Upper address bits above the index are ignored (aliasing wrap); not an error.
- BUSY: decrement the counter each edge. At the edge where counter==0, perform the access, pulse `dmem_resp`, and return to IDLE.
- Read: `dmem_rdata` ← array word. The whole word is returned regardless of rmask; the core extracts the bytes.
- Write: update only the bytes whose wmask bit is set; `dmem_rdata` ← 0.
- Both masks nonzero: treated as a write; set `protocol_err`.
- Request while BUSY: dropped, not queued; set `protocol_err`. In-flight access is unaffected.
- `dmem_rdata` holds its value until the next completion; `protocol_err` clears only on reset.
- Array contents are not reset (X until written).

## Timing
- Request sampled at edge E0. `dmem_resp` is high in the cycle after edge E0+LATENCY-1, i.e. LATENCY cycles after the request cycle.
- LATENCY=1: response appears in the cycle immediately after the request.
- The response cycle is IDLE, so a request presented in the same cycle as `dmem_resp` is accepted (no bubble). Sustained throughput is one request per LATENCY cycles.
- The array write occurs at the completion edge. A read accepted at or after that edge returns the new data.
- `busy` is high from the cycle after acceptance through the cycle before `dmem_resp`.
- Reset asserted mid-transaction: immediately IDLE, all outputs 0. A pending write is discarded and the array is untouched.

## Structure
- The `dmem_resp_state_t` enum (IDLE, BUSY) goes into the shared `rv32imc_types` package, next to the existing mem funct3 types.
- Sub-module `dmem_sram_array`: 2^DEPTH_LOG2 × 32, one synchronous port with a 4-bit byte write enable and registered read data; no reset.
- Top level holds the FSM, the latency counter, the captured request registers, and the error flag.

## Test plan
- Write then read, LATENCY=2: sw 0xDEADBEEF to 0x100 (wmask 0xF), then read 0x100 (rmask 0xF). Each `dmem_resp` arrives 2 cycles after its request; rdata = 0xDEADBEEF.
- Byte merge: after the above, sb 0x5A to byte 2 (wmask 0x4, wdata 0x005A0000); read 0x100 → 0xDE5ABEEF.
- Back-to-back, LATENCY=1: reads to 0x0, 0x4, 0x8 on consecutive cycles. Three `dmem_resp` pulses on consecutive cycles in order; `protocol_err` stays 0.
- Protocol errors: a request while `busy` is dropped (one response only) and `protocol_err`=1. A separate request with rmask=0xF and wmask=0x1 performs a write.
- Reset mid-flight, LATENCY=4: sw 0x12345678 to 0x20, rst_n low 2 cycles later. No `dmem_resp`, outputs 0. After writing 0 to 0x20 post-reset, a read of 0x20 returns 0.
- Aliasing, DEPTH_LOG2=10: write 0xCAFEF00D to 0x1000_0010; read 0x10 → 0xCAFEF00D.
